fetch_unit: RTL and testbench

- Program-counter and fetch-control stage directly upstream of the instruction ROM.
- Drives InstAddress into the ROM and watches the returned word for the all-ones halt encoding.
- Applies branch redirects through a 64-entry target LUT and runs the Start/Done handshake with the testbench.
- Keeps a saturating retired-instruction counter for performance checks.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/branch_lut.sv | 13 +
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states, halt encoding
// and the default branch-target table.
package fetch_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned INST_W = 9;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, HALT} fetch_state_t;

    localparam logic [INST_W-1:0] HALT_WORD = {INST_W{1'b1}};

    typedef logic [63:0][ADDR_W-1:0] branch_tbl_t;

    // Identity map except for the two program-specific redirects.
    function automatic branch_tbl_t gen_branch_tgt();
        branch_tbl_t t;
        for (int i = 0; i < 64; i++) begin
            t[i] = ADDR_W'(i);
        end
        t[0]  = ADDR_W'(4);
        t[10] = ADDR_W'(15);
        return t;
    endfunction

    localparam branch_tbl_t BRANCH_TGT = gen_branch_tgt();

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target lookup: 6-bit index to an A-bit fetch address.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int unsigned A = ADDR_W
) (
    input  logic [5:0]   idx,
    output logic [A-1:0] tgt
);

    assign tgt = A'(BRANCH_TGT[idx]);

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch control: Start/Done handshake, branch redirect,
// halt detection and a saturating retired-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned A  = ADDR_W,
    parameter int unsigned W  = INST_W,
    parameter int unsigned CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic [W-1:0]  InstIn,
    input  logic          BranchEn,
    input  logic [5:0]    BranchIdx,
    output logic [A-1:0]  InstAddress,
    output logic          Done,
    output logic [CW-1:0] InstCount
);

    fetch_state_t  state_q, state_d;
    logic [A-1:0]  pc_q, pc_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [A-1:0]  branch_tgt;
    logic [CW-1:0] cnt_inc;
    logic          halt;

    branch_lut #(
        .A (A)
    ) u_branch_lut (
        .idx (BranchIdx),
        .tgt (branch_tgt)
    );

    assign halt    = &InstIn;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (Start) state_d = ARMED;
            end
            ARMED: begin
                if (!Start) state_d = RUN;
            end
            RUN: begin
                if (Start) begin
                    state_d = ARMED;
                end else if (halt) begin
                    // Halt word is not retired and wins over stall/branch.
                    state_d = HALT;
                    done_d  = 1'b1;
                end else if (!Stall) begin
                    pc_d  = BranchEn ? branch_tgt : pc_q + A'(1);
                    cnt_d = cnt_inc;
                end
            end
            HALT: begin
                if (Start) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
        // Every edge that lands in ARMED clears the core.
        if (state_d == ARMED) begin
            pc_d   = '0;
            done_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InstAddress = pc_q;
    assign Done        = done_q;
    assign InstCount   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: launch, branch, stall, halt, wrap, restart,
// async reset and counter saturation (second instance with a 4-bit counter).
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Stall;
    logic [8:0]  InstIn;
    logic        BranchEn;
    logic [5:0]  BranchIdx;
    logic [9:0]  InstAddress, addr4;
    logic        Done, done4;
    logic [15:0] InstCount;
    logic [3:0]  cnt4;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    fetch_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Stall       (Stall),
        .InstIn      (InstIn),
        .BranchEn    (BranchEn),
        .BranchIdx   (BranchIdx),
        .InstAddress (InstAddress),
        .Done        (Done),
        .InstCount   (InstCount)
    );

    fetch_unit #(
        .CW (4)
    ) dut4 (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Stall       (Stall),
        .InstIn      (InstIn),
        .BranchEn    (BranchEn),
        .BranchIdx   (BranchIdx),
        .InstAddress (addr4),
        .Done        (done4),
        .InstCount   (cnt4)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int pc, input int cnt, input int dn);
        check({tag, ".addr"}, 32'(InstAddress), 32'(pc));
        check({tag, ".cnt"}, 32'(InstCount), 32'(cnt));
        check({tag, ".done"}, 32'(Done), 32'(dn));
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; InstIn = 9'h000;
        BranchEn = 1'b0; BranchIdx = 6'd0;
        tick(); tick();
        check_all("reset", 0, 0, 0);
        check("reset.cnt4", 32'(cnt4), 32'd0);
        Reset = 1'b0;

        // Launch: two cycles of Start, then release.
        Start = 1'b1;
        tick(); check_all("armed0", 0, 0, 0);
        tick(); check_all("armed1", 0, 0, 0);
        Start = 1'b0;
        tick(); check_all("run0", 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            tick(); check_all("seq", i, i, 0);
        end

        // Branch redirects through the LUT.
        BranchEn = 1'b1; BranchIdx = 6'd10;
        tick(); check_all("br10", 15, 6, 0);
        BranchIdx = 6'd0;
        tick(); check_all("br0", 4, 7, 0);
        BranchEn = 1'b0;
        tick(); tick(); tick(); check_all("to7", 7, 10, 0);

        // Stall holds PC and count.
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_all("stall", 7, 10, 0);
        end
        Stall = 1'b0;
        tick(); check_all("unstall", 8, 11, 0);
        BranchEn = 1'b1; BranchIdx = 6'd37;
        tick(); check_all("br37", 37, 12, 0);
        BranchIdx = 6'd10;
        tick(); check_all("br10b", 15, 13, 0);

        // Halt beats stall and branch; state stays frozen afterwards.
        InstIn = 9'h1FF; Stall = 1'b1; BranchEn = 1'b1;
        tick(); check_all("halt", 15, 13, 1);
        check("halt.cnt4", 32'(cnt4), 32'd13);
        tick(); tick(); check_all("halt.hold", 15, 13, 1);

        // Restart from HALT clears on the Start edge.
        Start = 1'b1;
        tick(); check_all("restart", 0, 0, 0);
        Start = 1'b0; InstIn = 9'h000; Stall = 1'b0; BranchEn = 1'b0;
        tick(); check_all("rerun0", 0, 0, 0);

        // Long run up to the top address, then wrap; the 4-bit counter saturates.
        for (int i = 0; i < 1023; i++) tick();
        check_all("top", 1023, 1023, 0);
        check("sat.cnt4", 32'(cnt4), 32'd15);
        tick(); check_all("wrap", 0, 1024, 0);
        tick(); check_all("wrap1", 1, 1025, 0);
        check("sat.hold", 32'(cnt4), 32'd15);
        check("addr4", 32'(addr4), 32'd1);

        // Asynchronous reset between clock edges.
        #2 Reset = 1'b1;
        #1 check_all("areset", 0, 0, 0);
        check("areset.cnt4", 32'(cnt4), 32'd0);
        #1 Reset = 1'b0;

        // Branch and stall in IDLE have no effect.
        BranchEn = 1'b1; BranchIdx = 6'd10; Stall = 1'b1;
        tick(); tick(); check_all("idle", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
